// File: rtl/axi4_sram_slave.sv
// AXI4 slave terminating one burst at a time into an internal word-addressed SRAM.
// Latency: WREADY 1 cycle after AW, BVALID 1 cycle after last W, first RVALID 2 cycles after AR.
// Backpressure: W accepted when WVALID; B/R outputs and read address hold while BREADY/RREADY are low.
module axi4_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  // write address channel
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [7:0]              awlen_i,
  input  logic [2:0]              awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  // write response channel
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  // read address channel
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [7:0]              arlen_i,
  input  logic [2:0]              arsize_i,
  input  logic [1:0]              arburst_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  // read data channel
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = $clog2(STRB_WIDTH);
  localparam int IDXW       = $clog2(MEM_WORDS);
  localparam logic [2:0] NATIVE_SIZE = 3'(OFFS);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t                  state_q;
  logic                    prio_rd_q;   // 1: read wins the next AW/AR collision
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;      // address of the beat currently being serviced
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    dec_q;       // some write beat was out of range
  logic                    slv_q;       // some write beat had a size/burst/WLAST error
  logic [ID_WIDTH-1:0]     bid_q;
  logic [1:0]              bresp_q;
  logic                    bvalid_q;
  logic [ID_WIDTH-1:0]     rid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic                    rlast_q;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

  logic [IDXW-1:0]         idx;
  logic                    range_err, size_err, burst_err, wlast_err, last_beat;
  logic                    mem_we;
  logic [1:0]              beat_resp;
  logic [ADDR_WIDTH-1:0]   bytes, wrap_mask, next_addr;

  // Per-beat decode: word index, error classification, next address and handshake readies
  always_comb begin
    idx       = addr_q[OFFS +: IDXW];
    range_err = (addr_q >> (OFFS + IDXW)) != '0;
    size_err  = size_q != NATIVE_SIZE;
    burst_err = (burst_q == 2'b11) ||
                (burst_q == BURST_WRAP && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));
    last_beat = cnt_q == len_q;
    wlast_err = wlast_i != last_beat;
    bytes     = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    if (burst_q == BURST_FIXED)
      next_addr = addr_q;
    else if (burst_q == BURST_WRAP && !burst_err)
      next_addr = (addr_q & ~wrap_mask) | ((addr_q + bytes) & wrap_mask);
    else
      next_addr = addr_q + bytes;   // INCR, and illegal bursts degraded to INCR
    beat_resp = range_err ? RESP_DECERR : ((size_err || burst_err) ? RESP_SLVERR : RESP_OKAY);
    mem_we    = (state_q == WDATA) && wvalid_i &&
                !range_err && !size_err && !burst_err && !wlast_err;
    awready_o = (state_q == IDLE) && awvalid_i && (!arvalid_i || !prio_rd_q);
    arready_o = (state_q == IDLE) && arvalid_i && (!awvalid_i || prio_rd_q);
    wready_o  = state_q == WDATA;
  end

  // Transaction FSM: arbitration, burst sequencing and registered B/R outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prio_rd_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      dec_q     <= 1'b0;
      slv_q     <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      bvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          dec_q <= 1'b0;
          slv_q <= 1'b0;
          if (awready_o) begin
            id_q      <= awid_i;
            addr_q    <= awaddr_i;
            len_q     <= awlen_i;
            size_q    <= awsize_i;
            burst_q   <= awburst_i;
            prio_rd_q <= 1'b1;
            state_q   <= WDATA;
          end else if (arready_o) begin
            id_q      <= arid_i;
            addr_q    <= araddr_i;
            len_q     <= arlen_i;
            size_q    <= arsize_i;
            burst_q   <= arburst_i;
            prio_rd_q <= 1'b0;
            state_q   <= RDATA;
          end
        end
        WDATA: begin
          if (wvalid_i) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
            dec_q  <= dec_q | range_err;
            slv_q  <= slv_q | size_err | burst_err | wlast_err;
            // Burst length is governed by LEN alone; a stray WLAST only marks an error
            if (last_beat) begin
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (dec_q || range_err) ? RESP_DECERR :
                          ((slv_q || size_err || burst_err || wlast_err) ? RESP_SLVERR : RESP_OKAY);
              state_q  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RDATA: begin
          if (rvalid_q && rready_i && rlast_q) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            state_q  <= IDLE;
          end else if (!rvalid_q || rready_i) begin
            // Output slot is free: fetch the next beat; a stalled beat is left untouched
            rvalid_q <= 1'b1;
            rid_q    <= id_q;
            rresp_q  <= beat_resp;
            rlast_q  <= last_beat;
            rdata_q  <= (beat_resp == RESP_OKAY) ? mem_q[idx] : '0;
            addr_q   <= next_addr;
            cnt_q    <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte-lane SRAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb_i[i]) mem_q[idx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign bid_o    = bid_q;
  assign bresp_o  = bresp_q;
  assign bvalid_o = bvalid_q;
  assign rid_o    = rid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;
  assign rlast_o  = rlast_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: 64-bit bus, 1024 words.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// All response waits are bounded; an expired bound is reported as a failed comparison.
module tb_axi4_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready, rlast, rvalid, rready;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axi4_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
    .rready_i(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Valid-side senders are called 1 time unit after a rising edge
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check("aw_accept", awready, 1);
    cyc();
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check("ar_accept", arready, 1);
    cyc();
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 50) begin @(negedge clk); n++; end
    check("w_accept", wready, 1);
    cyc();
    wvalid = 1'b0;
  endtask

  // Ready-side receivers check the pending beat before raising ready for one edge
  task automatic b_recv(input string tag, input logic [1:0] resp, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, bvalid, 1);
    check({tag, "_bid_bresp"}, {bid, bresp}, {id, resp});
    bready = 1'b1;
    cyc();
    bready = 1'b0;
  endtask

  task automatic r_recv(input string tag, input logic [63:0] data, input logic [1:0] resp,
                        input logic last, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, rvalid, 1);
    check({tag, "_rdata"}, rdata, data);
    check({tag, "_rid_rresp_rlast"}, {rid, rresp, rlast}, {id, resp, last});
    rready = 1'b1;
    cyc();
    rready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_handshake", {awready, wready, arready, bvalid, rvalid, rlast}, 6'b0);
    check("reset_rdata", rdata, 64'h0);
    check("reset_ids_resps", {bid, bresp, rid, rresp}, 12'h0);
    @(posedge clk); #2 reset = 1'b0;
    cyc();

    // Single write then read at 0x40
    aw_send(4'd1, 32'h40, 8'd0, 3'd3, 2'b01);
    @(negedge clk);
    check("wready_after_aw", wready, 1);
    cyc();
    w_beat(64'h1122334455667788, 8'hFF, 1'b1);
    @(negedge clk);
    check("bvalid_after_last_w", bvalid, 1);
    b_recv("single_b", 2'b00, 4'd1);
    ar_send(4'd2, 32'h40, 8'd0, 3'd3, 2'b01);
    @(negedge clk);
    check("rvalid_lat_c1", rvalid, 0);
    @(negedge clk);
    check("rvalid_lat_c2", rvalid, 1);
    r_recv("single_r", 64'h1122334455667788, 2'b00, 1'b1, 4'd2);

    // INCR burst with a 3-cycle WVALID gap before beat 2
    aw_send(4'd3, 32'h100, 8'd3, 3'd3, 2'b01);
    w_beat(64'd0, 8'hFF, 1'b0);
    w_beat(64'd1, 8'hFF, 1'b0);
    repeat (3) cyc();
    w_beat(64'd2, 8'hFF, 1'b0);
    w_beat(64'd3, 8'hFF, 1'b1);
    b_recv("incr_b", 2'b00, 4'd3);
    ar_send(4'd4, 32'h100, 8'd3, 3'd3, 2'b01);
    begin
      int n = 0;
      @(negedge clk);
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
    end
    check("incr_stall_b0", {rvalid, rlast, rdata}, {1'b1, 1'b0, 64'd0});
    @(negedge clk);
    check("incr_stall_b0_hold", {rvalid, rlast, rdata}, {1'b1, 1'b0, 64'd0});
    r_recv("incr_r0", 64'd0, 2'b00, 1'b0, 4'd4);
    r_recv("incr_r1", 64'd1, 2'b00, 1'b0, 4'd4);
    @(negedge clk);
    check("incr_stall_b2_hold", {rvalid, rlast, rdata}, {1'b1, 1'b0, 64'd2});
    r_recv("incr_r2", 64'd2, 2'b00, 1'b0, 4'd4);
    r_recv("incr_r3", 64'd3, 2'b00, 1'b1, 4'd4);
    @(negedge clk);
    check("incr_rvalid_drop", rvalid, 0);
    cyc();

    // WRAP LEN=3 from 0x18: beats land at 0x18, 0x00, 0x08, 0x10
    aw_send(4'd5, 32'h18, 8'd3, 3'd3, 2'b10);
    w_beat(64'hA0, 8'hFF, 1'b0);
    w_beat(64'hA1, 8'hFF, 1'b0);
    w_beat(64'hA2, 8'hFF, 1'b0);
    w_beat(64'hA3, 8'hFF, 1'b1);
    b_recv("wrap_b", 2'b00, 4'd5);
    ar_send(4'd5, 32'h00, 8'd3, 3'd3, 2'b01);
    r_recv("wrap_r00", 64'hA1, 2'b00, 1'b0, 4'd5);
    r_recv("wrap_r08", 64'hA2, 2'b00, 1'b0, 4'd5);
    r_recv("wrap_r10", 64'hA3, 2'b00, 1'b0, 4'd5);
    r_recv("wrap_r18", 64'hA0, 2'b00, 1'b1, 4'd5);

    // Collisions after reset: write wins first, then the waiting read wins the next one
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    awid = 4'd6; awaddr = 32'h200; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd7; araddr = 32'h40;  arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    check("collide1_grant_aw", {awready, arready}, 2'b10);
    cyc();
    awvalid = 1'b0;
    @(negedge clk);
    check("collide1_ar_waits", arready, 0);
    cyc();
    w_beat(64'hDEAD, 8'hFF, 1'b1);
    b_recv("collide1_b", 2'b00, 4'd6);
    awid = 4'd8; awaddr = 32'h208; awvalid = 1'b1;
    @(negedge clk);
    check("collide2_grant_ar", {awready, arready}, 2'b01);
    cyc();
    arvalid = 1'b0;
    r_recv("collide2_r", 64'h1122334455667788, 2'b00, 1'b1, 4'd7);
    @(negedge clk);
    check("collide2_aw_next", awready, 1);
    cyc();
    awvalid = 1'b0;
    w_beat(64'hBEEF, 8'hFF, 1'b1);
    b_recv("collide2_b", 2'b00, 4'd8);

    // Error responses: out-of-range word, wrong SIZE, early WLAST
    aw_send(4'd9, 32'h2000, 8'd0, 3'd3, 2'b01);
    w_beat(64'hBAD0, 8'hFF, 1'b1);
    b_recv("err_range_b", 2'b11, 4'd9);
    aw_send(4'd10, 32'h08, 8'd0, 3'd2, 2'b01);
    w_beat(64'hBAD1, 8'hFF, 1'b1);
    b_recv("err_size_b", 2'b10, 4'd10);
    aw_send(4'd11, 32'h300, 8'd3, 3'd3, 2'b01);
    w_beat(64'h30, 8'hFF, 1'b0);
    w_beat(64'h31, 8'hFF, 1'b1);
    w_beat(64'h32, 8'hFF, 1'b0);
    w_beat(64'h33, 8'hFF, 1'b1);
    b_recv("err_wlast_b", 2'b10, 4'd11);
    ar_send(4'd12, 32'h00, 8'd1, 3'd3, 2'b01);
    r_recv("err_mem_w0", 64'hA1, 2'b00, 1'b0, 4'd12);
    r_recv("err_mem_w1", 64'hA2, 2'b00, 1'b1, 4'd12);
    ar_send(4'd13, 32'h2000, 8'd0, 3'd3, 2'b01);
    r_recv("err_range_r", 64'h0, 2'b11, 1'b1, 4'd13);
    ar_send(4'd14, 32'h00, 8'd0, 3'd2, 2'b01);
    r_recv("err_size_r", 64'h0, 2'b10, 1'b1, 4'd14);

    // Reset during beat 2 of a LEN=7 read
    ar_send(4'd15, 32'h100, 8'd7, 3'd3, 2'b01);
    r_recv("rst_r0", 64'd0, 2'b00, 1'b0, 4'd15);
    r_recv("rst_r1", 64'd1, 2'b00, 1'b0, 4'd15);
    check("rst_beat2_pending", rvalid, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_rvalid_drop", rvalid, 0);
    check("rst_r_fields", {rid, rresp, rlast}, 7'h0);
    cyc();
    reset = 1'b0;
    arid = 4'd3; araddr = 32'h40; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    check("rst_ar_accept_now", arready, 1);
    cyc();
    arvalid = 1'b0;
    r_recv("rst_after_r", 64'h1122334455667788, 2'b00, 1'b1, 4'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
